// File: rtl/parking_elevator_scheduler.sv
// Parking-lot elevator scheduler: queues park/retrieve jobs in a FIFO and runs them one at a time.
// Optional macro PARK_ELEV_HOME_RETURN_EN: an idle, empty-queue elevator drifts back to floor 0.
module parking_elevator_scheduler #(
   parameter int QDEPTH    = 4,
   parameter int TOP_FLOOR = 7
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_dir,
   input  logic [15:0]               req_plate,
   input  logic [2:0]                req_floor,
   input  logic                      leakage,
   input  logic [2:0]                leakage_floor,
   output logic [2:0]                current_floor,
   output logic [15:0]               moving,
   output logic                      busy,
   output logic [$clog2(QDEPTH):0]   queue_count,
   output logic                      done_valid,
   output logic [15:0]               done_plate,
   output logic [2:0]                done_floor,
   output logic                      done_status
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [3:0]    TOP_F   = 4'(TOP_FLOOR);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PICK_MOVE = 3'd1,
      LOAD      = 3'd2,
      DEST_MOVE = 3'd3,
      UNLOAD    = 3'd4
   } state_e;

   function automatic logic [2:0] step_toward(input logic [2:0] cur, input logic [2:0] goal);
      logic [2:0] nxt;
      if (goal > cur) begin
         nxt = cur + 3'd1;
      end else if (goal < cur) begin
         nxt = cur - 3'd1;
      end else begin
         nxt = cur;
      end
      return nxt;
   endfunction

   // A leak on floor 0 never blocks or aborts anything.
   function automatic logic leak_hit(input logic leak, input logic [2:0] leak_fl, input logic [2:0] fl);
      return leak && (leak_fl == fl) && (leak_fl != 3'd0);
   endfunction

   state_e            state_q, state_d;
   logic [19:0]       fifo_q [QDEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              job_dir_q, job_dir_d;
   logic [15:0]       job_plate_q, job_plate_d;
   logic [2:0]        job_floor_q, job_floor_d;
   logic [2:0]        goal_q, goal_d;
   logic              abort_q, abort_d;
   logic [2:0]        cur_floor_q, cur_floor_d;
   logic [15:0]       moving_q, moving_d;
   logic              busy_q;
   logic              done_valid_q, done_valid_d;
   logic [15:0]       done_plate_q, done_plate_d;
   logic [2:0]        done_floor_q, done_floor_d;
   logic              done_status_q, done_status_d;

   logic              push_s, pop_s, reject_s, pick_abort_s, park_leak_s;
   logic [19:0]       head_s;
   logic              head_dir_s;
   logic [15:0]       head_plate_s;
   logic [2:0]        head_floor_s;
   logic [2:0]        dest_goal_s;

   assign req_ready    = (count_q < DEPTH_C);
   assign push_s       = req_valid && req_ready;
   assign pop_s        = (state_q == IDLE) && (count_q != '0);
   assign head_s       = fifo_q[rd_ptr_q];
   assign head_dir_s   = head_s[19];
   assign head_plate_s = head_s[18:3];
   assign head_floor_s = head_s[2:0];
   assign reject_s     = pop_s && ((head_floor_s == 3'd0) || ({1'b0, head_floor_s} > TOP_F) ||
                                   leak_hit(leakage, leakage_floor, head_floor_s));
   assign pick_abort_s = (state_q == PICK_MOVE) && job_dir_q &&
                         leak_hit(leakage, leakage_floor, job_floor_q);
   assign park_leak_s  = (state_q == DEST_MOVE) && !job_dir_q && !abort_q &&
                         leak_hit(leakage, leakage_floor, job_floor_q);
   assign dest_goal_s  = park_leak_s ? 3'd0 : goal_q;

   // FSM state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pop_s && !reject_s) state_d = PICK_MOVE;
            else                    state_d = IDLE;
         end
         PICK_MOVE: begin
            if (pick_abort_s)                 state_d = IDLE;
            else if (cur_floor_q == goal_q)   state_d = LOAD;
            else                              state_d = PICK_MOVE;
         end
         LOAD:      state_d = DEST_MOVE;
         DEST_MOVE: begin
            if (cur_floor_q == dest_goal_s) state_d = UNLOAD;
            else                            state_d = DEST_MOVE;
         end
         UNLOAD:    state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // FIFO pointer/occupancy next state
   always_comb begin
      wr_ptr_d = push_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Job, motion and completion datapath (FSM output logic)
   always_comb begin
      job_dir_d     = job_dir_q;
      job_plate_d   = job_plate_q;
      job_floor_d   = job_floor_q;
      goal_d        = goal_q;
      abort_d       = abort_q;
      cur_floor_d   = cur_floor_q;
      moving_d      = moving_q;
      done_valid_d  = 1'b0;
      done_plate_d  = done_plate_q;
      done_floor_d  = done_floor_q;
      done_status_d = done_status_q;
      case (state_q)
         IDLE: begin
            if (pop_s) begin
               job_dir_d   = head_dir_s;
               job_plate_d = head_plate_s;
               job_floor_d = head_floor_s;
               goal_d      = head_dir_s ? head_floor_s : 3'd0;
               abort_d     = 1'b0;
               if (reject_s) begin
                  done_valid_d  = 1'b1;
                  done_plate_d  = head_plate_s;
                  done_floor_d  = cur_floor_q;
                  done_status_d = 1'b1;
               end else begin
                  done_valid_d  = 1'b0;
               end
            end else begin
`ifdef PARK_ELEV_HOME_RETURN_EN
               if (cur_floor_q != 3'd0) cur_floor_d = cur_floor_q - 3'd1;
               else                     cur_floor_d = cur_floor_q;
`else
               cur_floor_d = cur_floor_q;
`endif
            end
         end
         PICK_MOVE: begin
            if (pick_abort_s) begin
               done_valid_d  = 1'b1;
               done_plate_d  = job_plate_q;
               done_floor_d  = cur_floor_q;
               done_status_d = 1'b1;
            end else begin
               cur_floor_d = step_toward(cur_floor_q, goal_q);
            end
         end
         LOAD: begin
            moving_d = job_plate_q;
            goal_d   = job_dir_q ? 3'd0 : job_floor_q;
         end
         DEST_MOVE: begin
            // A leak at the park target turns the car around immediately.
            if (park_leak_s) begin
               goal_d  = 3'd0;
               abort_d = 1'b1;
            end else begin
               goal_d  = goal_q;
            end
            cur_floor_d = step_toward(cur_floor_q, dest_goal_s);
         end
         UNLOAD: begin
            moving_d      = 16'h0000;
            done_valid_d  = 1'b1;
            done_plate_d  = job_plate_q;
            done_floor_d  = cur_floor_q;
            done_status_d = abort_q;
         end
         default: begin
            moving_d = moving_q;
         end
      endcase
   end

   // Datapath and FIFO registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= 20'h00000;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         job_dir_q     <= 1'b0;
         job_plate_q   <= 16'h0000;
         job_floor_q   <= 3'd0;
         goal_q        <= 3'd0;
         abort_q       <= 1'b0;
         cur_floor_q   <= 3'd0;
         moving_q      <= 16'h0000;
         busy_q        <= 1'b0;
         done_valid_q  <= 1'b0;
         done_plate_q  <= 16'h0000;
         done_floor_q  <= 3'd0;
         done_status_q <= 1'b0;
      end else begin
         if (push_s) fifo_q[wr_ptr_q] <= {req_dir, req_plate, req_floor};
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         job_dir_q     <= job_dir_d;
         job_plate_q   <= job_plate_d;
         job_floor_q   <= job_floor_d;
         goal_q        <= goal_d;
         abort_q       <= abort_d;
         cur_floor_q   <= cur_floor_d;
         moving_q      <= moving_d;
         busy_q        <= (state_d != IDLE);
         done_valid_q  <= done_valid_d;
         done_plate_q  <= done_plate_d;
         done_floor_q  <= done_floor_d;
         done_status_q <= done_status_d;
      end
   end

   assign current_floor = cur_floor_q;
   assign moving        = moving_q;
   assign busy          = busy_q;
   assign queue_count   = count_q;
   assign done_valid    = done_valid_q;
   assign done_plate    = done_plate_q;
   assign done_floor    = done_floor_q;
   assign done_status   = done_status_q;

endmodule

// File: tb/tb_parking_elevator_scheduler.sv
// Directed self-checking bench for parking_elevator_scheduler (default build, QDEPTH=4, TOP_FLOOR=7).
module tb_parking_elevator_scheduler;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_dir;
   logic [15:0] req_plate;
   logic [2:0]  req_floor;
   logic        leakage;
   logic [2:0]  leakage_floor;
   logic [2:0]  current_floor;
   logic [15:0] moving;
   logic        busy;
   logic [2:0]  queue_count;
   logic        done_valid;
   logic [15:0] done_plate;
   logic [2:0]  done_floor;
   logic        done_status;

   int n_assert = 0;
   int n_fail   = 0;

   parking_elevator_scheduler #(.QDEPTH(4), .TOP_FLOOR(7)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
      .req_plate(req_plate), .req_floor(req_floor),
      .leakage(leakage), .leakage_floor(leakage_floor),
      .current_floor(current_floor), .moving(moving), .busy(busy),
      .queue_count(queue_count),
      .done_valid(done_valid), .done_plate(done_plate),
      .done_floor(done_floor), .done_status(done_status)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic offer(input logic dir, input logic [15:0] plate, input logic [2:0] fl);
      req_valid = 1'b1;
      req_dir   = dir;
      req_plate = plate;
      req_floor = fl;
   endtask

   logic [2:0]  exp_fl  [8] = '{3'd3, 3'd2, 3'd2, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
   logic [15:0] exp_mv  [8] = '{16'h0, 16'h0, 16'h0, 16'h9423, 16'h9423, 16'h9423, 16'h9423, 16'h0};
   logic [15:0] q_plate [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
   logic        q_dir   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [2:0]  q_floor [5] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3};
   logic [2:0]  q_dfl   [4] = '{3'd1, 3'd0, 3'd2, 3'd0};
   logic [15:0] got_plate [4];
   logic [2:0]  got_floor [4];
   logic        got_stat  [4];
   int          n_done;
   int          wait_cnt;
   logic [2:0]  prev_fl;
   int          dones_seen;

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_dir = 1'b0; req_plate = 16'h0; req_floor = 3'd0;
      leakage = 1'b0; leakage_floor = 3'd0;
      tick(); tick();
      check("rst_floor", 32'(current_floor), 32'd0);
      check("rst_moving", 32'(moving), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(queue_count), 32'd0);
      check("rst_done", 32'({done_valid, done_plate, done_floor, done_status}), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd1);
      reset = 1'b1;
      tick();

      // Park 8754 to floor 3 (edge 0 = push)
      offer(1'b0, 16'h8754, 3'd3);
      tick();
      req_valid = 1'b0;
      check("p1_count_e0", 32'(queue_count), 32'd1);
      tick();
      check("p1_busy_e1", 32'(busy), 32'd1);
      check("p1_count_e1", 32'(queue_count), 32'd0);
      tick();
      check("p1_moving_e2", 32'(moving), 32'd0);
      tick();
      check("p1_moving_e3", 32'(moving), 32'h8754);
      check("p1_floor_e3", 32'(current_floor), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("p1_floor_e4_6", 32'(current_floor), 32'(k));
      end
      tick();
      check("p1_done_e7", 32'(done_valid), 32'd0);
      tick();
      check("p1_done_e8", 32'(done_valid), 32'd1);
      check("p1_dplate", 32'(done_plate), 32'h8754);
      check("p1_dfloor", 32'(done_floor), 32'd3);
      check("p1_dstat", 32'(done_status), 32'd0);
      check("p1_moving_e8", 32'(moving), 32'd0);
      tick();
      check("p1_pulse_end", 32'(done_valid), 32'd0);
      check("p1_idle", 32'(busy), 32'd0);

      // Retrieve 9423 from floor 2 while parked at floor 3
      offer(1'b1, 16'h9423, 3'd2);
      tick();
      req_valid = 1'b0;
      prev_fl = current_floor;
      check("r1_floor_e0", 32'(current_floor), 32'd3);
      for (int k = 0; k < 8; k++) begin
         tick();
         check("r1_floor", 32'(current_floor), 32'(exp_fl[k]));
         check("r1_moving", 32'(moving), 32'(exp_mv[k]));
         check("r1_step", 32'((current_floor > prev_fl ? current_floor - prev_fl : prev_fl - current_floor) <= 3'd1), 32'd1);
         prev_fl = current_floor;
      end
      check("r1_done", 32'(done_valid), 32'd1);
      check("r1_dfloor", 32'(done_floor), 32'd0);
      check("r1_dplate", 32'(done_plate), 32'h9423);
      check("r1_dstat", 32'(done_status), 32'd0);
      tick();

      // Long job keeps the car busy while five jobs are offered back-to-back
      offer(1'b0, 16'h0700, 3'd7);
      tick();
      for (int k = 0; k < 4; k++) begin
         offer(q_dir[k], q_plate[k], q_floor[k]);
         tick();
         check("q_count", 32'(queue_count), 32'(k + 1));
      end
      check("q_ready_full", 32'(req_ready), 32'd0);
      offer(q_dir[4], q_plate[4], q_floor[4]);
      tick();
      req_valid = 1'b0;
      check("q_count_full", 32'(queue_count), 32'd4);
      for (int k = 0; k < 6; k++) begin
         tick();
         check("q_ready_hold", 32'(req_ready), 32'd0);
      end
      tick();
      check("q0_done", 32'(done_valid), 32'd1);
      check("q0_dplate", 32'(done_plate), 32'h0700);
      check("q0_dfloor", 32'(done_floor), 32'd7);
      tick();
      check("q_ready_pop", 32'(req_ready), 32'd1);
      check("q_count_pop", 32'(queue_count), 32'd3);
      n_done = 0;
      wait_cnt = 0;
      while (n_done < 4 && wait_cnt < 300) begin
         tick();
         wait_cnt++;
         if (done_valid) begin
            if (n_done < 4) begin
               got_plate[n_done] = done_plate;
               got_floor[n_done] = done_floor;
               got_stat[n_done]  = done_status;
            end
            n_done++;
         end
      end
      check("q_ndone", 32'(n_done), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < n_done) begin
            check("q_order_plate", 32'(got_plate[k]), 32'(q_plate[k]));
            check("q_order_floor", 32'(got_floor[k]), 32'(q_dfl[k]));
            check("q_order_stat", 32'(got_stat[k]), 32'd0);
         end
      end
      tick(); tick();
      check("q_empty", 32'(queue_count), 32'd0);
      check("q_no_fifth", 32'(done_valid), 32'd0);

      // Leak on the target floor at pop rejects the park job
      leakage = 1'b1; leakage_floor = 3'd5;
      offer(1'b0, 16'h1234, 3'd5);
      tick();
      req_valid = 1'b0;
      tick();
      check("lk_done", 32'(done_valid), 32'd1);
      check("lk_stat", 32'(done_status), 32'd1);
      check("lk_plate", 32'(done_plate), 32'h1234);
      check("lk_dfloor", 32'(done_floor), 32'd0);
      check("lk_busy", 32'(busy), 32'd0);
      check("lk_moving", 32'(moving), 32'd0);
      tick();
      check("lk_floor", 32'(current_floor), 32'd0);
      check("lk_pulse_end", 32'(done_valid), 32'd0);
      leakage = 1'b0;

      // Floor 0 as target is an invalid job
      offer(1'b0, 16'h0909, 3'd0);
      tick();
      req_valid = 1'b0;
      tick();
      check("inv_done", 32'(done_valid), 32'd1);
      check("inv_stat", 32'(done_status), 32'd1);
      check("inv_plate", 32'(done_plate), 32'h0909);
      check("inv_busy", 32'(busy), 32'd0);
      tick();

      // Park to floor 6, leak on floor 6 when the car reaches floor 4
      offer(1'b0, 16'h6666, 3'd6);
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 7; k++) tick();
      check("ml_floor4", 32'(current_floor), 32'd4);
      check("ml_moving", 32'(moving), 32'h6666);
      leakage = 1'b1; leakage_floor = 3'd6;
      wait_cnt = 0;
      while (!done_valid && wait_cnt < 20) begin
         tick();
         wait_cnt++;
      end
      check("ml_done_seen", 32'(done_valid), 32'd1);
      check("ml_dfloor", 32'(done_floor), 32'd0);
      check("ml_dstat", 32'(done_status), 32'd1);
      check("ml_dplate", 32'(done_plate), 32'h6666);
      check("ml_moving0", 32'(moving), 32'd0);
      leakage = 1'b0;
      tick();

      // Reset mid-job with the car loaded at floor 2 and a job queued
      offer(1'b0, 16'h4321, 3'd4);
      tick();
      offer(1'b0, 16'h7777, 3'd1);
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check("rm_floor2", 32'(current_floor), 32'd2);
      check("rm_loaded", 32'(moving), 32'h4321);
      check("rm_queued", 32'(queue_count), 32'd1);
      reset = 1'b0;
      #1;
      check("rm_floor", 32'(current_floor), 32'd0);
      check("rm_moving", 32'(moving), 32'd0);
      check("rm_count", 32'(queue_count), 32'd0);
      check("rm_busy", 32'(busy), 32'd0);
      tick();
      reset = 1'b1;
      dones_seen = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (done_valid || busy) dones_seen++;
      end
      check("rm_no_done", 32'(dones_seen), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
